// File: rtl/systolic_tile_scheduler.sv
// rtl/systolic_tile_scheduler.sv - one-tile systolic matmul sequencer (optional SCHED_ABORT_EN adds abort/aborted)
module systolic_tile_scheduler #(
  parameter int ROWS          = 8,
  parameter int COLS          = 8,
  parameter int K_WIDTH       = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int ROW_IDX_WIDTH = 3,
  parameter int PE_LAT        = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [K_WIDTH-1:0]       k_len,
  input  logic [ADDR_WIDTH-1:0]    a_base,
  input  logic [ADDR_WIDTH-1:0]    b_base,
  output logic                     busy,
  output logic                     done,
  output logic                     acc_clear,
  output logic                     buf_rd_en,
  output logic [ADDR_WIDTH-1:0]    a_rd_addr,
  output logic [ADDR_WIDTH-1:0]    b_rd_addr,
  output logic                     feed_en,
  output logic                     res_valid,
  output logic [ROW_IDX_WIDTH-1:0] res_row,
`ifdef SCHED_ABORT_EN
  input  logic                     abort,
  output logic                     aborted,
`endif
  input  logic                     res_ready
);

  // Drain covers the feed register, the skew depth across the array and the PE pipeline.
  localparam int DRAIN_CYC = ROWS + COLS + PE_LAT;
  localparam int DW        = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_DRAIN, S_OUTPUT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [K_WIDTH-1:0] k_len_q;
  logic [K_WIDTH-1:0] load_cnt;
  logic [DW-1:0]      drain_cnt;
  logic               start_ok;
  logic               load_last;
  logic               drain_last;
  logic               row_last;
  logic               in_busy;
  logic               kill;

  assign start_ok   = start && (k_len != '0);
  assign load_last  = (load_cnt == k_len_q - K_WIDTH'(1));
  assign drain_last = (drain_cnt == DW'(DRAIN_CYC - 1));
  assign row_last   = (res_row == ROW_IDX_WIDTH'(ROWS - 1));
  assign in_busy    = (state_q == S_CLEAR) || (state_q == S_LOAD) ||
                      (state_q == S_DRAIN) || (state_q == S_OUTPUT);
  assign busy       = in_busy;

`ifdef SCHED_ABORT_EN
  assign kill = abort && in_busy;
`else
  assign kill = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and state-decoded strobes.
  always_comb begin
    state_d   = state_q;
    acc_clear = 1'b0;
    buf_rd_en = 1'b0;
    res_valid = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE:   if (start_ok) state_d = S_CLEAR;
      S_CLEAR: begin
        acc_clear = 1'b1;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        buf_rd_en = 1'b1;
        if (load_last) state_d = S_DRAIN;
      end
      S_DRAIN:  if (drain_last) state_d = S_OUTPUT;
      S_OUTPUT: begin
        res_valid = 1'b1;
        if (res_ready && row_last) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
  end

  // Latch tile parameters on an accepted start and step the read addresses through LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_len_q   <= '0;
      a_rd_addr <= '0;
      b_rd_addr <= '0;
    end else if (state_q == S_IDLE && start_ok) begin
      k_len_q   <= k_len;
      a_rd_addr <= a_base;
      b_rd_addr <= b_base;
    end else if (state_q == S_LOAD && !load_last) begin
      a_rd_addr <= a_rd_addr + ADDR_WIDTH'(1);
      b_rd_addr <= b_rd_addr + ADDR_WIDTH'(1);
    end
  end

  // Per-state cycle counters; each idles at zero outside its own state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      load_cnt  <= (state_q == S_LOAD)  ? load_cnt + K_WIDTH'(1) : '0;
      drain_cnt <= (state_q == S_DRAIN) ? drain_cnt + DW'(1)     : '0;
    end
  end

  // Result row index advances on each accepted row and rests at zero outside OUTPUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_row <= '0;
    end else if (state_q != S_OUTPUT) begin
      res_row <= '0;
    end else if (res_ready) begin
      res_row <= row_last ? '0 : res_row + ROW_IDX_WIDTH'(1);
    end
  end

  // Feed enable trails the buffer read by its one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) feed_en <= 1'b0;
    else        feed_en <= buf_rd_en;
  end

`ifdef SCHED_ABORT_EN
  // One-cycle flag for a tile cut short by abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) aborted <= 1'b0;
    else        aborted <= kill;
  end
`endif

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// tb/tb_systolic_tile_scheduler.sv - scoreboard bench for systolic_tile_scheduler (ROWS=COLS=4)
module tb_systolic_tile_scheduler;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KW   = 8;
  localparam int AW   = 8;
  localparam int RW   = 3;
  localparam int PL   = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic [AW-1:0] a_base = '0;
  logic [AW-1:0] b_base = '0;
  logic          busy, done, acc_clear, buf_rd_en, feed_en, res_valid;
  logic [AW-1:0] a_rd_addr, b_rd_addr;
  logic [RW-1:0] res_row;
  logic          res_ready = 1'b1;
`ifdef SCHED_ABORT_EN
  logic          abort = 1'b0;
  logic          aborted;
`endif

  systolic_tile_scheduler #(
    .ROWS(ROWS), .COLS(COLS), .K_WIDTH(KW), .ADDR_WIDTH(AW),
    .ROW_IDX_WIDTH(RW), .PE_LAT(PL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .a_base(a_base), .b_base(b_base), .busy(busy), .done(done),
    .acc_clear(acc_clear), .buf_rd_en(buf_rd_en),
    .a_rd_addr(a_rd_addr), .b_rd_addr(b_rd_addr), .feed_en(feed_en),
    .res_valid(res_valid), .res_row(res_row),
`ifdef SCHED_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kinds: 0 clear, 1 read, 2 feed, 3 row accepted, 4 done, 5 row held, 6 aborted
  typedef struct {
    int kind;
    int cyc;
    int v1;
    int v2;
  } evt_t;
  evt_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit tile_active = 1'b0;
  int tb_s = 0;
  int tb_end = 0;
  int st_from = 0;
  int st_len = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int v1, input int v2);
    evt_t e;
    e.kind = kind; e.cyc = c; e.v1 = v1; e.v2 = v2;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input int kind, input int v1, input int v2);
    evt_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", kind, 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      chk("evt_kind", kind, e.kind);
      chk("evt_cycle", cyc, e.cyc);
      chk("evt_v1", v1, e.v1);
      chk("evt_v2", v2, e.v2);
    end
  endtask

  // Reference event list for a tile: cycle n of the tile is cyc == base + n.
  task automatic gen(input int k, input int a, input int b, input int s_len,
                     input int abort_n, input int base, input int lim_n);
    int lim, out0, done_n;
    lim    = (abort_n != 0) ? abort_n : 1 << 30;
    out0   = 2 + k + (ROWS + COLS + PL);
    done_n = out0 + ROWS + s_len;
    for (int n = 1; n <= lim_n; n++) begin
      if (n == 1) push(0, base + n, 0, 0);
      if (n >= 2 && n < 2 + k && n <= lim) push(1, base + n, (a + n - 2) & 8'hFF, (b + n - 2) & 8'hFF);
      if (n >= 3 && n < 3 + k && n <= lim + 1) push(2, base + n, 0, 0);
      if (n <= lim) begin
        if (s_len > 0 && n >= out0 + 2 && n < out0 + 2 + s_len) push(5, base + n, 2, 0);
        else if (n >= out0 && n < out0 + ROWS + s_len)
          push(3, base + n, (n >= out0 + 2 + s_len) ? n - out0 - s_len : n - out0, 0);
      end
      if (abort_n == 0 && n == done_n) push(4, base + n, 0, 0);
      if (abort_n != 0 && n == abort_n + 1) push(6, base + n, 0, 0);
    end
  endtask

  // Monitor: drive the consumer's ready, then match every observed strobe to the scoreboard.
  always @(negedge clk) begin
    res_ready = !(st_len > 0 && cyc >= st_from && cyc < st_from + st_len);
    if (rst_n) begin
      chk("busy", busy, tile_active && cyc >= tb_s + 1 && cyc < tb_s + tb_end);
      if (acc_clear) pop_chk(0, 0, 0);
      if (buf_rd_en) pop_chk(1, a_rd_addr, b_rd_addr);
      if (feed_en)   pop_chk(2, 0, 0);
      if (res_valid) pop_chk(res_ready ? 3 : 5, res_row, 0);
      if (done)      pop_chk(4, 0, 0);
`ifdef SCHED_ABORT_EN
      if (aborted)   pop_chk(6, 0, 0);
`endif
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_acc_clear"}, acc_clear, 0);
    chk({tag, "_buf_rd_en"}, buf_rd_en, 0);
    chk({tag, "_a_rd_addr"}, a_rd_addr, 0);
    chk({tag, "_b_rd_addr"}, b_rd_addr, 0);
    chk({tag, "_feed_en"}, feed_en, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_row"}, res_row, 0);
`ifdef SCHED_ABORT_EN
    chk({tag, "_aborted"}, aborted, 0);
`endif
  endtask

  task automatic run_tile(input int k, input int a, input int b, input int s_len,
                          input bit inj, input int abort_n);
    int base, endn;
    @(negedge clk);
    start = 1'b1; k_len = KW'(k); a_base = AW'(a); b_base = AW'(b);
    base = cyc;
    endn = (abort_n != 0) ? abort_n + 1 : 2 + k + (ROWS + COLS + PL) + ROWS + s_len;
    gen(k, a, b, s_len, abort_n, base, endn);
    tb_s = base; tb_end = endn; tile_active = 1'b1;
    st_from = base + 2 + k + (ROWS + COLS + PL) + 2;
    st_len  = s_len;
    for (int n = 1; n <= endn; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (inj && n == 3) begin
        start = 1'b1; k_len = 8'd7; a_base = 8'h80; b_base = 8'h90;
      end
`ifdef SCHED_ABORT_EN
      abort = (abort_n != 0 && n == abort_n);
`endif
    end
    tile_active = 1'b0;
    st_len = 0;
    #1;
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 check_zero("reset");
    #1 rst_n = 1'b1;

    run_tile(3, 8'h10, 8'h20, 0, 1'b0, 0);
    run_tile(3, 8'h10, 8'h20, 5, 1'b0, 0);
    run_tile(4, 8'hFE, 8'h00, 0, 1'b0, 0);

    // k_len=0 start must leave the scheduler idle; the monitor flags any strobe.
    @(negedge clk);
    start = 1'b1; k_len = 8'd0; a_base = 8'h33; b_base = 8'h44;
    @(negedge clk);
    start = 1'b0;
    chk("kzero_busy", busy, 0);
    chk("kzero_acc_clear", acc_clear, 0);
    repeat (4) @(negedge clk);

    run_tile(3, 8'h10, 8'h20, 0, 1'b1, 0);

    // Reset in the middle of LOAD: only cycles 1..3 may have produced strobes.
    @(negedge clk);
    start = 1'b1; k_len = 8'd3; a_base = 8'h10; b_base = 8'h20;
    tb_s = cyc; tb_end = 1000; tile_active = 1'b1;
    gen(3, 8'h10, 8'h20, 0, 0, cyc, 3);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    chk("midreset_consumed", exp_q.size(), 0);
    tile_active = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    run_tile(3, 8'h10, 8'h20, 0, 1'b0, 0);

`ifdef SCHED_ABORT_EN
    run_tile(3, 8'h10, 8'h20, 0, 1'b0, 8);
    repeat (15) @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_tile_scheduler.md
Name: systolic_tile_scheduler

Overview:
Top-level sequencer for one matrix-multiply tile on the systolic array. On start it clears the PE accumulators and reads K operand vectors from the A/B operand buffers. It drives the skewing input controller's enable, waits for the array to drain, then hands result rows to the output side under a valid/ready handshake. It sits between the host/command logic and the input controller plus PE array.

Parameters:
ROWS, 8, PE array rows (A lanes)
COLS, 8, PE array columns (B lanes)
K_WIDTH, 8, width of the K-depth field; max depth 2^K_WIDTH-1
ADDR_WIDTH, 8, operand buffer address width
ROW_IDX_WIDTH, 3, width of the result row index (≥ clog2(ROWS))
PE_LAT, 1, PE MAC latency in cycles

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin tile; sampled only in IDLE
k_len  in  K_WIDTH  number of K steps; latched on accepted start
a_base  in  ADDR_WIDTH  A buffer start address; latched on accepted start
b_base  in  ADDR_WIDTH  B buffer start address; latched on accepted start
busy  out  1  tile in progress
done  out  1  one-cycle pulse, tile complete
acc_clear  out  1  one-cycle pulse, clears PE accumulators
buf_rd_en  out  1  operand buffer read enable
a_rd_addr  out  ADDR_WIDTH  A buffer read address
b_rd_addr  out  ADDR_WIDTH  B buffer read address
feed_en  out  1  enable to input skew controller
res_valid  out  1  result row available
res_row  out  ROW_IDX_WIDTH  index of result row offered
res_ready  in  1  consumer accepts row

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, including addresses and res_row. Counters 0. Reset mid-tile aborts immediately with no done pulse.
- Cycle n means n rising edges after the edge that samples an accepted start.
- States: IDLE, CLEAR, LOAD, DRAIN, OUTPUT, DONE.
- IDLE: start=1 and k_len!=0 → CLEAR. Latch k_len, a_base, b_base. start with k_len=0 is ignored: stay IDLE, no outputs change.
- CLEAR (1 cycle): acc_clear=1, busy=1 → LOAD.
- LOAD (k_len cycles): buf_rd_en=1. Addresses are a_base+i and b_base+i for i=0..k_len-1, all registered outputs. Addresses wrap modulo 2^ADDR_WIDTH. After the k_len-th read → DRAIN.
- feed_en = buf_rd_en delayed exactly 1 cycle, matching the 1-cycle buffer read latency. It is independent of state, so its last pulse lands in the first DRAIN cycle.
- DRAIN: fixed ROWS+COLS+PE_LAT cycles. This covers the feed delay, the skew depth and the PE latency. Then → OUTPUT.
- OUTPUT: res_valid=1, res_row starts at 0. res_row increments on each cycle with res_valid&&res_ready.
- res_valid and res_row hold stable while res_ready=0; there is no timeout.
- After row ROWS-1 is accepted → DONE. res_valid drops in that same transition.
- DONE (1 cycle): done=1, busy=0 → IDLE. A start in the next cycle is accepted normally.
- busy=1 in CLEAR, LOAD, DRAIN and OUTPUT; 0 in IDLE and DONE.
- start while not in IDLE is ignored; latched parameters are unaffected.
- acc_clear, done and buf_rd_en never assert outside their states.

Optional Feature:
Macro SCHED_ABORT_EN.
- When defined: adds input abort (1 bit) and output aborted (1 bit, reset 0).
- abort=1 sampled in any busy state forces IDLE on the next edge. That edge deasserts buf_rd_en, res_valid and busy. feed_en follows its 1-cycle delay, so it may carry one final pulse. aborted pulses for 1 cycle; done does not pulse.
- abort in IDLE or DONE has no effect.
- When undefined: no such ports; behaviour exactly as above.

Test Plan:
- Nominal tile (ROWS=COLS=4, PE_LAT=1, res_ready=1), start with k_len=3, a_base=0x10, b_base=0x20:
  - acc_clear at cycle 1.
  - buf_rd_en at cycles 2–4 with a_rd_addr 0x10,0x11,0x12 and b_rd_addr 0x20,0x21,0x22.
  - feed_en at cycles 3–5; DRAIN at cycles 5–13.
  - res_valid at cycles 14–17 with res_row 0..3.
  - done at cycle 18; busy high for cycles 1–17.
- Backpressure: same tile with res_ready=0 for 5 cycles at row 2 → res_valid=1 and res_row=2 held stable; done delayed by exactly 5 cycles.
- Address wrap: a_base=0xFE, k_len=4 → a_rd_addr 0xFE,0xFF,0x00,0x01.
- Ignored starts: k_len=0 start → no state change. start pulsed during LOAD with k_len=7 → the original tile completes with 3 reads.
- Reset mid-LOAD: rst_n low at cycle 3 → all outputs 0 asynchronously and no done. A start afterwards runs the full nominal sequence.
- (SCHED_ABORT_EN) abort at cycle 8 in DRAIN → IDLE and aborted=1 at cycle 9; no res_valid; no done.
